// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU. Single-cycle add/sub/logic/shift ops, plus iterative
// signed multiply (shift-add) and divide (restoring) on operand magnitudes.
// R15 carries the product high half or the remainder.
// Optional build macro: SEQ_ALU_DIVZ_EN adds a divz flag that pulses with done
// when a DIV was executed with a zero divisor.
module seq_alu #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       ctrl,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res,
`ifdef SEQ_ALU_DIVZ_EN
    output logic             divz,
`endif
    output logic [WIDTH-1:0] R15
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state;
    logic             is_div, neg_a, neg_b, bzero;
    logic [WIDTH-1:0] a_r;     // original dividend, returned as remainder on b=0
    logic [WIDTH-1:0] m;       // multiplicand / divisor magnitude
    logic [WIDTH-1:0] acc;     // product high half / partial remainder
    logic [WIDTH-1:0] q;       // multiplier bits / quotient bits
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] sc_res, abs_a, abs_b, sra_v;
    logic [SHW-1:0]   sh;
    logic [WIDTH:0]   mul_sum, r2;
    logic [WIDTH-1:0] diff, acc_n, q_n, quot, remv;
    logic [2*WIDTH-1:0] prod, prod_s;
    logic             ge, neg_r;

    assign busy  = (state != IDLE);
    assign sh    = b[SHW-1:0];
    assign abs_a = a[WIDTH-1] ? ('0 - a) : a;
    assign abs_b = b[WIDTH-1] ? ('0 - b) : b;
    assign sra_v = $signed(a) >>> sh;

    // Single-cycle result selection
    always_comb begin
        sc_res = '0;
        case (ctrl)
            4'b0000: sc_res = a + b;
            4'b0001: sc_res = a - b;
            4'b0010: sc_res = a & b;
            4'b0011: sc_res = a | b;
            4'b0100: sc_res = a ^ b;
            4'b0101: sc_res = a << sh;
            4'b0110: sc_res = a >> sh;
            4'b0111: sc_res = sra_v;
            default: sc_res = '0;
        endcase
    end

    // One iteration step; the last step is folded into FIX so the result
    // registers on the WIDTH-th edge after acceptance
    always_comb begin
        mul_sum = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
        r2      = {acc, q[WIDTH-1]};
        ge      = (r2 >= {1'b0, m});
        diff    = r2[WIDTH-1:0] - m;
        if (is_div) begin
            acc_n = ge ? diff : r2[WIDTH-1:0];
            q_n   = {q[WIDTH-2:0], ge};
        end else begin
            acc_n = mul_sum[WIDTH:1];
            q_n   = {mul_sum[0], q[WIDTH-1:1]};
        end
        neg_r  = neg_a ^ neg_b;
        prod   = {acc_n, q_n};
        prod_s = neg_r ? ('0 - prod) : prod;
        quot   = neg_r ? ('0 - q_n) : q_n;
        remv   = neg_a ? ('0 - acc_n) : acc_n;
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            done   <= 1'b0;
            res    <= '0;
            R15    <= '0;
            is_div <= 1'b0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            bzero  <= 1'b0;
            a_r    <= '0;
            m      <= '0;
            acc    <= '0;
            q      <= '0;
            cnt    <= '0;
`ifdef SEQ_ALU_DIVZ_EN
            divz   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef SEQ_ALU_DIVZ_EN
            divz <= 1'b0;
`endif
            case (state)
                IDLE: if (start) begin
                    if (ctrl == 4'b1000 || ctrl == 4'b1001) begin
                        state  <= CALC;
                        cnt    <= CW'(WIDTH);
                        is_div <= ctrl[0];
                        neg_a  <= a[WIDTH-1];
                        neg_b  <= b[WIDTH-1];
                        bzero  <= (b == '0);
                        a_r    <= a;
                        acc    <= '0;
                        m      <= ctrl[0] ? abs_b : abs_a;
                        q      <= ctrl[0] ? abs_a : abs_b;
                    end else begin
                        res  <= sc_res;
                        R15  <= '0;
                        done <= 1'b1;
                    end
                end
                CALC: begin
                    acc <= acc_n;
                    q   <= q_n;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(2)) state <= FIX;
                end
                FIX: begin
                    if (is_div) begin
                        if (bzero) begin
                            res <= '1;
                            R15 <= a_r;
`ifdef SEQ_ALU_DIVZ_EN
                            divz <= 1'b1;
`endif
                        end else begin
                            res <= quot;
                            R15 <= remv;
                        end
                    end else begin
                        {R15, res} <= prod_s;
                    end
                    cnt   <= '0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, multi-cycle successor to the 16-bit combinational ALU. It adds width generalisation, shifts, and iterative signed multiply/divide. The auxiliary R15 result carries the product high half or the remainder. A start/busy/done handshake lets the datapath controller stall on long operations. The block sits in the execute stage and drives the result bus and the R15 write port.

Parameters:
WIDTH, 16, operand/result width in bits (>=4, power of two)
SHW, $clog2(WIDTH), shift-amount bits taken from b[SHW-1:0]

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; a/b/ctrl sampled on the rising edge where start=1 and block is idle
a  input  WIDTH  operand A (dividend / multiplicand)
b  input  WIDTH  operand B (divisor / multiplier / shift amount)
ctrl  input  4  operation select
busy  output  1  high while an operation is in flight
done  output  1  one-cycle pulse; res/R15 valid from this cycle
res  output  WIDTH  primary result (low product / quotient)
R15  output  WIDTH  auxiliary result (high product / remainder; 0 otherwise)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, res=0, R15=0; internal accumulators cleared.
- Deassertion mid-operation aborts the operation; the block always restarts from IDLE.
- States: IDLE, CALC, FIX.
  - IDLE + start: latch a, b, ctrl.
    - Single-cycle op: result registered on the same edge, done=1 next cycle, stay IDLE.
    - MUL/DIV: go to CALC, load counter=WIDTH.
  - CALC: one shift-add (MUL) or restoring shift-subtract (DIV) step per cycle on operand magnitudes; counter decrements; at 1 go to FIX.
  - FIX: apply signs, register res/R15, pulse done, go to IDLE.
- Latency, measured in rising edges after the accepting edge:
  - Single-cycle ops: 1.
  - MUL/DIV: WIDTH+1 (17 for WIDTH=16).
- busy = (state != IDLE). busy is 0 in the done cycle, so a new start may be accepted in the done cycle.
- start while busy=1 is ignored, not queued. Inputs changing mid-operation have no effect.
- done is high for exactly one cycle per accepted start.
- res/R15 hold their value until the next done; they never glitch mid-operation.
- ctrl encoding:
  - 0000 ADD, 0001 SUB: modulo 2^WIDTH, R15=0.
  - 0010 AND, 0011 OR, 0100 XOR: R15=0.
  - 0101 SLL, 0110 SRL, 0111 SRA: shift a by b[SHW-1:0], R15=0.
  - 1000 MUL: signed; {R15,res} = full 2*WIDTH product.
  - 1001 DIV: signed, truncate toward zero; res=quotient, R15=remainder, remainder sign = dividend sign.
  - 1010-1111: res=0, R15=0, single-cycle latency.
- DIV boundaries:
  - b=0: res = all ones, R15 = a, normal latency.
  - Most-negative / -1: res = most-negative (wrap), R15 = 0.

Optional Feature:
SEQ_ALU_DIVZ_EN
- Defined: adds output divz (1 bit, reset 0). divz pulses with done when DIV is executed with b=0; it is 0 on every other done. res/R15 values are unchanged from the base behaviour.
- Undefined: no divz port; the divide-by-zero result values still apply.

Test Plan:
- Reset release, then start with ctrl=0000, a=0x0002, b=0x0001 -> done 1 edge later, res=0x0003, R15=0x0000, busy never high.
- MUL a=0x0004, b=0x0003 -> busy high 16 cycles, done at edge 17, res=0x000C, R15=0x0000; a second start pulse raised at edge 5 is ignored (exactly one done).
- MUL a=0xFFFE (-2), b=0x0003 -> res=0xFFFA, R15=0xFFFF; MUL 0x8000*0x8000 -> res=0x0000, R15=0x4000.
- DIV a=0x0007, b=0xFFFE (-2) -> res=0xFFFD, R15=0x0001; DIV 0x8000/0xFFFF -> res=0x8000, R15=0x0000.
- DIV a=0x1234, b=0x0000 -> res=0xFFFF, R15=0x1234; with SEQ_ALU_DIVZ_EN, divz=1 in the done cycle only.
- Start DIV, pull rst_n low at edge 8 -> busy/done/res/R15 go 0 immediately; no done follows; the next SRA a=0x8000, b=0x0004 gives res=0xF800.
